usb_rx_pkt_decode: RTL and testbench
====================================

# usb_rx_pkt_decode

Receive-side packet decoder between the byte-level receiver (bit-unstuffed, NRZI-decoded byte stream) and the DATA-phase stage `crc16_r`.
- Validates every PID byte.
- Consumes token and handshake packets locally and checks the token CRC5.
- Reports decoded fields to link control.
- Forwards only DATA packets, PID byte included, through a one-entry register slice using the same sop/eop/valid/ready convention.

## Interface
Parameters: none.

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- rx_pkt_sop  in  1  first byte of packet
- rx_pkt_eop  in  1  last byte of packet
- rx_pkt_valid  in  1  byte valid
- rx_pkt_ready  out  1  byte accepted when valid&&ready
- rx_pkt_data  in  8  received byte, bit0 = first on wire
- rx_sop  out  1  DATA packet first byte (PID), to crc16_r
- rx_eop  out  1  DATA packet last byte
- rx_valid  out  1  forward byte valid
- rx_ready  in  1  downstream accept
- rx_data  out  8  forwarded byte
- rx_pid  out  4  last accepted PID[3:0], held
- rx_pid_vld  out  1  pulse: valid PID accepted
- rx_pid_err  out  1  pulse: PID check failed
- rx_token_vld  out  1  pulse: token complete, CRC5 good
- rx_token_err  out  1  pulse: token CRC5 or length error
- rx_addr  out  7  token address, held
- rx_endp  out  4  token endpoint, held
- rx_hs_vld  out  1  pulse: 1-byte handshake received

## Operation
Outputs that are low after reset: all outputs except `rx_pkt_ready`, which is high. The state machine resets to IDLE.

PID classification:
- Check: `data[7:4] == ~data[3:0]`.
- Token: PID[1:0]=01 (OUT 0001, IN 1001, SOF 0101, SETUP 1101).
- Data: PID[1:0]=11.
- Handshake: PID[1:0]=10.
- PID[1:0]=00 (special): treated as a PID error.

States:
- **IDLE:** a byte with sop is the PID.
  - Bad PID: `rx_pid_err`; go to DROP, or stay in IDLE if eop.
  - Good PID: update `rx_pid` and pulse `rx_pid_vld`, then branch on type.
  - Token → TOK1.
  - Data → DATA; the PID byte is forwarded with `rx_sop`=1.
  - Handshake → if eop, pulse `rx_hs_vld`; else go to DROP.
  - Bytes without sop in IDLE are accepted and discarded.
- **TOK1:** capture byte 1 (`addr[6:0]` = bits 6:0, `endp[0]` = bit 7) → TOK2. If eop: `rx_token_err`, → IDLE.
- **TOK2:** byte 2: `endp[3:1]` = bits 2:0, crc5 = bits 7:3.
  - CRC5 check: poly x^5+x^2+1, seed 5'b11111, run LSB-first over all 16 bits of bytes 1–2. Residual must equal 5'b01100.
  - eop and residual ok: `rx_token_vld`; update `rx_addr`/`rx_endp`; → IDLE.
  - eop and residual bad: `rx_token_err`; → IDLE; `rx_addr`/`rx_endp` unchanged.
  - No eop: `rx_token_err`; → DROP.
- **DATA:** forward every byte; eop is forwarded as `rx_eop` → IDLE. No length or CRC16 check here.
- **DROP:** accept and discard bytes until eop → IDLE.

Boundary rules:
- **sop in a non-IDLE state:** abort the current packet and process that byte as a new PID.
  - Aborted token: `rx_token_err`.
  - Aborted DATA: no `rx_eop` is forwarded for it.
- **Byte without sop in IDLE:** accepted and discarded.
- **Forward slice:** one register entry, `slot_vld`.
  - Load on accept of a forwarded byte.
  - Clear on `rx_valid && rx_ready` with no new load.
  - Simultaneous load and drain: slot replaced.
- **Back-pressure:** `rx_pkt_ready = !slot_vld || rx_ready`, applied in all states. This keeps byte order across packet boundaries.

## Timing
- Accepted byte at edge N → forwarded `rx_valid`/`rx_data`/`rx_sop`/`rx_eop` at N+1, held while `!rx_ready`.
- `rx_pid_vld`, `rx_pid_err`, `rx_token_vld`, `rx_token_err`, `rx_hs_vld` are registered one-cycle pulses asserted the cycle after the triggering byte is accepted.
- `rx_pid` updates together with `rx_pid_vld`; `rx_addr`/`rx_endp` update together with `rx_token_vld`.
- Throughput: one byte per cycle when `rx_ready`=1.
- Reset mid-packet: all state cleared immediately; the slot is emptied and no pulse is produced.

## Test plan
- SETUP token 0x2D,0x00,0x10 (sop on 1st, eop on 3rd):
  - `rx_token_vld` once, `rx_pid`=0xD, `rx_addr`=0, `rx_endp`=0.
  - No `rx_valid`.
- OUT token 0xE1,0x00,0x11 (corrupted CRC): `rx_token_err` once, no `rx_token_vld`, `rx_addr`/`rx_endp` unchanged.
- DATA0 0xC3,0x01,0x02,0xAA,0x55:
  - Five bytes forwarded in order, 1-cycle latency.
  - `rx_sop` on 0xC3, `rx_eop` on 0x55, `rx_pid`=0x3.
- Same DATA0 with `rx_ready` low for 3 cycles on byte 2:
  - `rx_pkt_ready` drops; `rx_data` holds 0x01.
  - No loss or duplication; the subsequent bytes still arrive in order.
- Handshakes:
  - ACK 0xD2 (sop+eop): `rx_hs_vld`, `rx_pid`=0x2.
  - Bad PID 0xD3 (sop+eop): `rx_pid_err` only.
  - 2-byte ACK: `rx_pid_vld`, no `rx_hs_vld`, second byte dropped.
- Token 0x69,0x00 then new sop 0xC3...: `rx_token_err` on the 0xC3 accept; the DATA packet is forwarded normally.

Source files
------------

// File: rtl/usb_rx_pkt_decode.sv
// Receive-side USB packet decoder: validates PIDs, consumes tokens/handshakes locally
// (token CRC5 check) and forwards DATA packets through a one-entry register slice.
module usb_rx_pkt_decode (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_pkt_sop,
   input  logic       rx_pkt_eop,
   input  logic       rx_pkt_valid,
   output logic       rx_pkt_ready,
   input  logic [7:0] rx_pkt_data,
   output logic       rx_sop,
   output logic       rx_eop,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic [3:0] rx_pid,
   output logic       rx_pid_vld,
   output logic       rx_pid_err,
   output logic       rx_token_vld,
   output logic       rx_token_err,
   output logic [6:0] rx_addr,
   output logic [3:0] rx_endp,
   output logic       rx_hs_vld
);

   typedef enum logic [2:0] {IDLE, TOK1, TOK2, DATA, DROP} state_t;

   state_t     state_q;
   logic [7:0] tok_b1_q;
   logic [3:0] pid_q;
   logic [6:0] addr_q;
   logic [3:0] endp_q;
   logic       pid_vld_q, pid_err_q, tok_vld_q, tok_err_q, hs_vld_q;
   logic       slot_vld_q, slot_sop_q, slot_eop_q;
   logic [7:0] slot_data_q;

   logic       accept_s;
   logic       pid_ok_s;
   logic       fwd_s;
   logic       tok_crc_ok_s;

   // USB CRC5 (x^5+x^2+1), seed all-ones, LSB-first; returns the residual
   function automatic logic [4:0] crc5_residual(input logic [15:0] bits);
      logic [4:0] crc;
      logic       fb;
      crc = 5'b11111;
      for (int i = 0; i < 16; i++) begin
         fb  = crc[4] ^ bits[i];
         crc = {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
      end
      return crc;
   endfunction

   assign rx_pkt_ready = !slot_vld_q || rx_ready;
   assign accept_s     = rx_pkt_valid && rx_pkt_ready;
   assign tok_crc_ok_s = (crc5_residual({rx_pkt_data, tok_b1_q}) == 5'b01100);

   // PID check and decision whether the current byte goes to the forward slice
   always_comb begin
      pid_ok_s = (rx_pkt_data[7:4] == ~rx_pkt_data[3:0]) && (rx_pkt_data[1:0] != 2'b00);
      if (rx_pkt_sop) begin
         fwd_s = pid_ok_s && (rx_pkt_data[1:0] == 2'b11);
      end else begin
         fwd_s = (state_q == DATA);
      end
   end

   // Packet state machine with registered status pulses and held fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         tok_b1_q  <= 8'h00;
         pid_q     <= 4'h0;
         addr_q    <= 7'h00;
         endp_q    <= 4'h0;
         pid_vld_q <= 1'b0;
         pid_err_q <= 1'b0;
         tok_vld_q <= 1'b0;
         tok_err_q <= 1'b0;
         hs_vld_q  <= 1'b0;
      end else begin
         pid_vld_q <= 1'b0;
         pid_err_q <= 1'b0;
         tok_vld_q <= 1'b0;
         tok_err_q <= 1'b0;
         hs_vld_q  <= 1'b0;
         if (accept_s) begin
            if (rx_pkt_sop) begin
               // A new sop always restarts; an interrupted token counts as a token error
               if (state_q == TOK1 || state_q == TOK2) begin
                  tok_err_q <= 1'b1;
               end
               if (!pid_ok_s) begin
                  pid_err_q <= 1'b1;
                  state_q   <= rx_pkt_eop ? IDLE : DROP;
               end else begin
                  pid_vld_q <= 1'b1;
                  pid_q     <= rx_pkt_data[3:0];
                  case (rx_pkt_data[1:0])
                     2'b01: begin
                        if (rx_pkt_eop) begin
                           tok_err_q <= 1'b1;
                           state_q   <= IDLE;
                        end else begin
                           state_q   <= TOK1;
                        end
                     end
                     2'b11: state_q <= rx_pkt_eop ? IDLE : DATA;
                     2'b10: begin
                        if (rx_pkt_eop) begin
                           hs_vld_q <= 1'b1;
                           state_q  <= IDLE;
                        end else begin
                           state_q  <= DROP;
                        end
                     end
                     default: state_q <= DROP;
                  endcase
               end
            end else begin
               case (state_q)
                  IDLE: state_q <= IDLE;
                  TOK1: begin
                     tok_b1_q <= rx_pkt_data;
                     if (rx_pkt_eop) begin
                        tok_err_q <= 1'b1;
                        state_q   <= IDLE;
                     end else begin
                        state_q   <= TOK2;
                     end
                  end
                  TOK2: begin
                     if (rx_pkt_eop && tok_crc_ok_s) begin
                        tok_vld_q <= 1'b1;
                        addr_q    <= tok_b1_q[6:0];
                        endp_q    <= {rx_pkt_data[2:0], tok_b1_q[7]};
                        state_q   <= IDLE;
                     end else begin
                        tok_err_q <= 1'b1;
                        state_q   <= rx_pkt_eop ? IDLE : DROP;
                     end
                  end
                  DATA:    state_q <= rx_pkt_eop ? IDLE : DATA;
                  DROP:    state_q <= rx_pkt_eop ? IDLE : DROP;
                  default: state_q <= IDLE;
               endcase
            end
         end
      end
   end

   // One-entry forward slice; a load while draining replaces the entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_vld_q  <= 1'b0;
         slot_sop_q  <= 1'b0;
         slot_eop_q  <= 1'b0;
         slot_data_q <= 8'h00;
      end else if (accept_s && fwd_s) begin
         slot_vld_q  <= 1'b1;
         slot_sop_q  <= rx_pkt_sop;
         slot_eop_q  <= rx_pkt_eop;
         slot_data_q <= rx_pkt_data;
      end else if (rx_ready) begin
         slot_vld_q  <= 1'b0;
      end else begin
         slot_vld_q  <= slot_vld_q;
      end
   end

   assign rx_valid     = slot_vld_q;
   assign rx_sop       = slot_vld_q && slot_sop_q;
   assign rx_eop       = slot_vld_q && slot_eop_q;
   assign rx_data      = slot_data_q;
   assign rx_pid       = pid_q;
   assign rx_addr      = addr_q;
   assign rx_endp      = endp_q;
   assign rx_pid_vld   = pid_vld_q;
   assign rx_pid_err   = pid_err_q;
   assign rx_token_vld = tok_vld_q;
   assign rx_token_err = tok_err_q;
   assign rx_hs_vld    = hs_vld_q;

endmodule

// File: tb/tb_usb_rx_pkt_decode.sv
// Directed self-checking bench for usb_rx_pkt_decode; expected values are hand-computed.
module tb_usb_rx_pkt_decode;

   logic       clk;
   logic       rst_n;
   logic       rx_pkt_sop, rx_pkt_eop, rx_pkt_valid, rx_pkt_ready;
   logic [7:0] rx_pkt_data;
   logic       rx_sop, rx_eop, rx_valid, rx_ready;
   logic [7:0] rx_data;
   logic [3:0] rx_pid;
   logic       rx_pid_vld, rx_pid_err, rx_token_vld, rx_token_err, rx_hs_vld;
   logic [6:0] rx_addr;
   logic [3:0] rx_endp;
   logic [4:0] pulses;
   logic       acc;
   int         checks;
   int         errors;

   // Pulse vector order: {pid_vld, pid_err, token_vld, token_err, hs_vld}
   localparam logic [4:0] P_NONE = 5'b00000;
   localparam logic [4:0] P_PID  = 5'b10000;
   localparam logic [4:0] P_PERR = 5'b01000;
   localparam logic [4:0] P_TOK  = 5'b00100;
   localparam logic [4:0] P_TERR = 5'b00010;
   localparam logic [4:0] P_HS   = 5'b00001;

   assign pulses = {rx_pid_vld, rx_pid_err, rx_token_vld, rx_token_err, rx_hs_vld};

   usb_rx_pkt_decode dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_pkt_sop   (rx_pkt_sop),
      .rx_pkt_eop   (rx_pkt_eop),
      .rx_pkt_valid (rx_pkt_valid),
      .rx_pkt_ready (rx_pkt_ready),
      .rx_pkt_data  (rx_pkt_data),
      .rx_sop       (rx_sop),
      .rx_eop       (rx_eop),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rx_data      (rx_data),
      .rx_pid       (rx_pid),
      .rx_pid_vld   (rx_pid_vld),
      .rx_pid_err   (rx_pid_err),
      .rx_token_vld (rx_token_vld),
      .rx_token_err (rx_token_err),
      .rx_addr      (rx_addr),
      .rx_endp      (rx_endp),
      .rx_hs_vld    (rx_hs_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of input at the falling edge, return after the next falling edge
   task automatic step(input logic v, input logic s, input logic e, input logic [7:0] d,
                       input logic rdy);
      rx_pkt_valid = v;
      rx_pkt_sop   = s;
      rx_pkt_eop   = e;
      rx_pkt_data  = d;
      rx_ready     = rdy;
      #1;
      acc = rx_pkt_valid && rx_pkt_ready;
      @(posedge clk);
      @(negedge clk);
      rx_pkt_valid = 1'b0;
      rx_pkt_sop   = 1'b0;
      rx_pkt_eop   = 1'b0;
   endtask

   task automatic chk_fwd(input string tag, input logic [7:0] d, input logic s, input logic e);
      chk({tag, " valid"}, {31'd0, rx_valid}, 32'd1);
      chk({tag, " data"},  {24'd0, rx_data}, {24'd0, d});
      chk({tag, " sop"},   {31'd0, rx_sop}, {31'd0, s});
      chk({tag, " eop"},   {31'd0, rx_eop}, {31'd0, e});
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b0;
      rx_pkt_valid = 1'b0;
      rx_pkt_sop   = 1'b0;
      rx_pkt_eop   = 1'b0;
      rx_pkt_data  = 8'h00;
      rx_ready     = 1'b1;
      acc          = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset valid",  {31'd0, rx_valid}, 32'd0);
      chk("reset ready",  {31'd0, rx_pkt_ready}, 32'd1);
      chk("reset pulses", {27'd0, pulses}, {27'd0, P_NONE});
      chk("reset pid",    {28'd0, rx_pid}, 32'd0);
      chk("reset addr",   {25'd0, rx_addr}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // SETUP addr 0 endp 0
      step(1'b1, 1'b1, 1'b0, 8'h2D, 1'b1);
      chk("setup0 pid pulse", {27'd0, pulses}, {27'd0, P_PID});
      chk("setup0 pid",       {28'd0, rx_pid}, 32'hD);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("setup0 b1 pulses", {27'd0, pulses}, {27'd0, P_NONE});
      step(1'b1, 1'b0, 1'b1, 8'h10, 1'b1);
      chk("setup0 tok pulse", {27'd0, pulses}, {27'd0, P_TOK});
      chk("setup0 addr",      {25'd0, rx_addr}, 32'd0);
      chk("setup0 endp",      {28'd0, rx_endp}, 32'd0);
      chk("setup0 no fwd",    {31'd0, rx_valid}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("setup0 single pulse", {27'd0, pulses}, {27'd0, P_NONE});

      // SETUP addr 1 endp 0 (CRC5 field 0b10111)
      step(1'b1, 1'b1, 1'b0, 8'h2D, 1'b1);
      step(1'b1, 1'b0, 1'b0, 8'h01, 1'b1);
      step(1'b1, 1'b0, 1'b1, 8'hE8, 1'b1);
      chk("setup1 tok pulse", {27'd0, pulses}, {27'd0, P_TOK});
      chk("setup1 addr",      {25'd0, rx_addr}, 32'd1);
      chk("setup1 endp",      {28'd0, rx_endp}, 32'd0);

      // OUT with corrupted CRC: fields must hold
      step(1'b1, 1'b1, 1'b0, 8'hE1, 1'b1);
      chk("out pid", {28'd0, rx_pid}, 32'h1);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b0, 1'b1, 8'h11, 1'b1);
      chk("out crc err pulse", {27'd0, pulses}, {27'd0, P_TERR});
      chk("out addr held",     {25'd0, rx_addr}, 32'd1);
      chk("out endp held",     {28'd0, rx_endp}, 32'd0);

      // DATA0 at full rate
      step(1'b1, 1'b1, 1'b0, 8'hC3, 1'b1);
      chk_fwd("data0 b0", 8'hC3, 1'b1, 1'b0);
      chk("data0 pid pulse", {27'd0, pulses}, {27'd0, P_PID});
      chk("data0 pid",       {28'd0, rx_pid}, 32'h3);
      step(1'b1, 1'b0, 1'b0, 8'h01, 1'b1);
      chk_fwd("data0 b1", 8'h01, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h02, 1'b1);
      chk_fwd("data0 b2", 8'h02, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'hAA, 1'b1);
      chk_fwd("data0 b3", 8'hAA, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
      chk_fwd("data0 b4", 8'h55, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("data0 drained", {31'd0, rx_valid}, 32'd0);

      // DATA0 with downstream stall while byte 0x01 is held
      step(1'b1, 1'b1, 1'b0, 8'hC3, 1'b1);
      chk_fwd("stall b0", 8'hC3, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h01, 1'b1);
      chk_fwd("stall b1", 8'h01, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 8'h02, 1'b0);
         chk($sformatf("stall accept %0d", i), {31'd0, acc}, 32'd0);
         chk($sformatf("stall ready %0d", i), {31'd0, rx_pkt_ready}, 32'd0);
         chk_fwd($sformatf("stall hold %0d", i), 8'h01, 1'b0, 1'b0);
      end
      step(1'b1, 1'b0, 1'b0, 8'h02, 1'b1);
      chk("stall release accept", {31'd0, acc}, 32'd1);
      chk_fwd("stall b2", 8'h02, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'hAA, 1'b1);
      chk_fwd("stall b3", 8'hAA, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
      chk_fwd("stall b4", 8'h55, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("stall drained", {31'd0, rx_valid}, 32'd0);

      // Handshakes
      step(1'b1, 1'b1, 1'b1, 8'hD2, 1'b1);
      chk("ack pulses", {27'd0, pulses}, {27'd0, P_PID | P_HS});
      chk("ack pid",    {28'd0, rx_pid}, 32'h2);
      step(1'b1, 1'b1, 1'b1, 8'hD3, 1'b1);
      chk("badpid pulses", {27'd0, pulses}, {27'd0, P_PERR});
      chk("badpid pid held", {28'd0, rx_pid}, 32'h2);
      step(1'b1, 1'b1, 1'b0, 8'hD2, 1'b1);
      chk("ack2 b0 pulses", {27'd0, pulses}, {27'd0, P_PID});
      step(1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
      chk("ack2 b1 pulses", {27'd0, pulses}, {27'd0, P_NONE});
      chk("ack2 no fwd",    {31'd0, rx_valid}, 32'd0);

      // IN token aborted by a DATA0 sop
      step(1'b1, 1'b1, 1'b0, 8'h69, 1'b1);
      chk("in pid", {28'd0, rx_pid}, 32'h9);
      step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b1, 1'b0, 8'hC3, 1'b1);
      chk("abort pulses", {27'd0, pulses}, {27'd0, P_PID | P_TERR});
      chk_fwd("abort d0", 8'hC3, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h11, 1'b1);
      chk_fwd("abort d1", 8'h11, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 8'h22, 1'b1);
      chk_fwd("abort d2", 8'h22, 1'b0, 1'b1);
      chk("abort addr held", {25'd0, rx_addr}, 32'd1);

      // Stray byte without sop in IDLE is swallowed
      step(1'b1, 1'b0, 1'b0, 8'h77, 1'b1);
      chk("stray accept",  {31'd0, acc}, 32'd1);
      chk("stray no fwd",  {31'd0, rx_valid}, 32'd0);
      chk("stray pulses",  {27'd0, pulses}, {27'd0, P_NONE});

      // Reset in the middle of a DATA packet
      step(1'b1, 1'b1, 1'b0, 8'hC3, 1'b1);
      chk_fwd("rst d0", 8'hC3, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst valid",  {31'd0, rx_valid}, 32'd0);
      chk("midrst pulses", {27'd0, pulses}, {27'd0, P_NONE});
      chk("midrst pid",    {28'd0, rx_pid}, 32'd0);
      chk("midrst addr",   {25'd0, rx_addr}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0, 8'h01, 1'b1);
      chk("postrst no fwd", {31'd0, rx_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
